// File: rtl/mips_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// mips_pkg : shared fetch-stage types and constants
// Rev 1.0
// ----------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_HALT_PEND = 2'd2,
    ST_HALT      = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;
  localparam int          PC_INC         = 4;

endpackage
`default_nettype wire

// File: rtl/if_stage_fetch_if.sv
`default_nettype none
// ----------------------------------------------------------------
// if_stage_fetch_if : hazard, redirect, imem and IF/ID signals of fetch
// Rev 1.0
// ----------------------------------------------------------------
interface if_stage_fetch_if #(
  parameter int PC_W  = 5,
  parameter int CNT_W = 16
);
  logic             stall_F;
  logic             stall_D;
  logic             flush_D;
  logic             pc_src_D;
  logic [PC_W-1:0]  pc_target_D;
  logic [PC_W-1:0]  imem_addr;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr_D;
  logic [PC_W-1:0]  pc_plus4_D;
  logic             valid_D;
  logic             halted;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output stall_F, stall_D, flush_D, pc_src_D, pc_target_D, imem_rdata,
    input  imem_addr, instr_D, pc_plus4_D, valid_D, halted,
           fetch_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall_F, stall_D, flush_D, pc_src_D, pc_target_D, imem_rdata,
    output imem_addr, instr_D, pc_plus4_D, valid_D, halted,
           fetch_cnt, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones, sync active-low clear
// Rev 1.0
// ----------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;
endmodule
`default_nettype wire

// File: rtl/if_stage_fetch.sv
`default_nettype none
// ----------------------------------------------------------------
// if_stage_fetch : MIPS IF stage - PC, IF/ID register, halt detect, counters
// Rev 1.0
// ----------------------------------------------------------------
module if_stage_fetch
  import mips_pkg::*;
#(
  parameter int          PC_W       = 5,
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF,
  parameter int          CNT_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  if_stage_fetch_if.slave bus
);
  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_plus4_q, pc_plus4_d;
  logic            valid_q, valid_d;

  logic [PC_W-1:0]  w_pc_plus4;
  logic             w_run;
  logic             w_ifid_load;
  logic             w_halt_det;
  logic [CNT_W-1:0] w_fetch_cnt, w_stall_cnt, w_flush_cnt;

  assign w_pc_plus4  = pc_q + PC_W'(PC_INC);
  assign w_run       = (state_q == ST_RUN);
  assign w_ifid_load = !bus.flush_D && !bus.stall_D;
  assign w_halt_det  = w_run && w_ifid_load && (bus.imem_rdata == HALT_INSTR);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        // A committed halt freezes PC even if decode also asks for a redirect
        if (w_halt_det)           state_d = ST_HALT_PEND;
        else if (bus.pc_src_D)    pc_d    = bus.pc_target_D;
        else if (!bus.stall_F)    pc_d    = w_pc_plus4;
      end
      ST_HALT_PEND: begin
        if (bus.flush_D) begin
          state_d = ST_RUN;
          if (bus.pc_src_D) pc_d = bus.pc_target_D;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if ((state_q == ST_HALT) || bus.flush_D) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (!bus.stall_D) begin
      if (w_run) begin
        instr_d    = bus.imem_rdata;
        pc_plus4_d = w_pc_plus4;
        valid_d    = 1'b1;
      end else begin
        instr_d    = NOP_INSTR;
        pc_plus4_d = '0;
        valid_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= PC_W'(RESET_PC);
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
    .clk(clk), .clr_n_i(reset), .inc_i(w_run && w_ifid_load), .cnt_o(w_fetch_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .clr_n_i(reset), .inc_i(w_run && bus.stall_F), .cnt_o(w_stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .clr_n_i(reset),
    .inc_i(bus.flush_D && (state_q != ST_BOOT) && (state_q != ST_HALT)),
    .cnt_o(w_flush_cnt)
  );

  assign bus.imem_addr  = pc_q;
  assign bus.instr_D    = instr_q;
  assign bus.pc_plus4_D = pc_plus4_q;
  assign bus.valid_D    = valid_q;
  assign bus.halted     = (state_q == ST_HALT);
  assign bus.fetch_cnt  = w_fetch_cnt;
  assign bus.stall_cnt  = w_stall_cnt;
  assign bus.flush_cnt  = w_flush_cnt;
endmodule
`default_nettype wire

// File: tb/tb_if_stage_fetch.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_if_stage_fetch : scoreboard bench for the fetch stage
// Rev 1.0
// ----------------------------------------------------------------
module tb_if_stage_fetch;
  import mips_pkg::*;

  localparam int          PC_W    = 5;
  localparam int          CNT_W   = 5;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam int          ADDR_N  = 1 << PC_W;
  localparam logic [31:0] FILL    = 32'h2001_0005;

  typedef struct {
    int          addr;
    logic [31:0] instr;
    int          p4;
    bit          v;
    bit          h;
    int          fc;
    int          sc;
    int          flc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] mem [ADDR_N];
  exp_t q [$];
  int n_vec = 0;
  int n_mis = 0;

  if_stage_fetch_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();
  assign bus.imem_rdata = mem[bus.imem_addr];

  if_stage_fetch #(
    .PC_W(PC_W), .RESET_PC(32'd0), .HALT_INSTR(HALT_INSTR_DEF), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: a program counter plus a few status flags
  int          m_pc;
  bit          m_boot, m_pend, m_halted;
  logic [31:0] m_instr;
  int          m_p4;
  bit          m_v;
  int          m_fc, m_sc, m_flc;

  function automatic int sat(input int x);
    return (x < CNT_MAX) ? x + 1 : x;
  endfunction

  task automatic model_step(input bit rst_n, sF, sD, fD, src, input int tgt);
    logic [31:0] word;
    int plus4;
    bit running;
    if (!rst_n) begin
      m_pc = 0; m_instr = 32'h0; m_p4 = 0; m_v = 0;
      m_boot = 1; m_pend = 0; m_halted = 0;
      m_fc = 0; m_sc = 0; m_flc = 0;
      return;
    end
    word    = mem[m_pc];
    plus4   = (m_pc + 4) % ADDR_N;
    running = !m_boot && !m_pend && !m_halted;
    if (running && !fD && !sD) m_fc = sat(m_fc);
    if (running && sF) m_sc = sat(m_sc);
    if (fD && !m_boot && !m_halted) m_flc = sat(m_flc);
    if (m_halted || fD) begin
      m_instr = 32'h0; m_p4 = 0; m_v = 0;
    end else if (!sD) begin
      if (running) begin m_instr = word; m_p4 = plus4; m_v = 1; end
      else begin m_instr = 32'h0; m_p4 = 0; m_v = 0; end
    end
    if (m_boot) begin
      m_boot = 0;
    end else if (running) begin
      if (word == HALT_INSTR_DEF && !fD && !sD) m_pend = 1;
      else if (src) m_pc = tgt;
      else if (!sF) m_pc = plus4;
    end else if (m_pend) begin
      m_pend = 0;
      if (fD) begin
        if (src) m_pc = tgt;
      end else begin
        m_halted = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic step(input bit rst_n, sF, sD, fD, src, input int tgt);
    exp_t e;
    reset           = rst_n;
    bus.stall_F     = sF;
    bus.stall_D     = sD;
    bus.flush_D     = fD;
    bus.pc_src_D    = src;
    bus.pc_target_D = PC_W'(tgt);
    model_step(rst_n, sF, sD, fD, src, tgt);
    e = '{m_pc, m_instr, m_p4, m_v, m_halted, m_fc, m_sc, m_flc};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a new IF/ID + PC view
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("imem_addr",  32'(bus.imem_addr),  32'(e.addr));
      chk("instr_D",    bus.instr_D,         e.instr);
      chk("pc_plus4_D", 32'(bus.pc_plus4_D), 32'(e.p4));
      chk("valid_D",    32'(bus.valid_D),    32'(e.v));
      chk("halted",     32'(bus.halted),     32'(e.h));
      chk("fetch_cnt",  32'(bus.fetch_cnt),  32'(e.fc));
      chk("stall_cnt",  32'(bus.stall_cnt),  32'(e.sc));
      chk("flush_cnt",  32'(bus.flush_cnt),  32'(e.flc));
    end
  end

  initial begin
    for (int i = 0; i < ADDR_N; i++) mem[i] = FILL;
    reset = 1'b0;
    bus.stall_F = 0; bus.stall_D = 0; bus.flush_D = 0;
    bus.pc_src_D = 0; bus.pc_target_D = '0;

    // Free run with wrap 28 -> 0
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("boot_bubble", 32'(bus.valid_D), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("first_p4", 32'(bus.pc_plus4_D), 32'd4);
    chk("first_valid", 32'(bus.valid_D), 32'd1);
    run_n(7);
    chk("wrap_addr", 32'(bus.imem_addr), 32'd0);
    chk("wrap_p4", 32'(bus.pc_plus4_D), 32'd0);

    // Stall at PC=8
    step(0, 0, 0, 0, 0, 0);
    run_n(3);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0);
    chk("stall_addr", 32'(bus.imem_addr), 32'd8);
    chk("stall_p4_held", 32'(bus.pc_plus4_D), 32'd8);
    chk("stall_cnt3", 32'(bus.stall_cnt), 32'd3);
    chk("stall_fetch_cnt", 32'(bus.fetch_cnt), 32'd2);

    // Redirect beats stall_F, flush beats load
    run_n(1);
    step(1, 1, 0, 1, 1, 20);
    chk("redir_addr", 32'(bus.imem_addr), 32'd20);
    chk("redir_instr", bus.instr_D, 32'h0);
    chk("redir_valid", 32'(bus.valid_D), 32'd0);
    chk("redir_flush_cnt", 32'(bus.flush_cnt), 32'd1);

    // Halt committed at PC=16
    mem[16] = HALT_INSTR_DEF;
    step(0, 0, 0, 0, 0, 0);
    run_n(6);
    chk("halt_latched", bus.instr_D, HALT_INSTR_DEF);
    chk("halt_pend_addr", 32'(bus.imem_addr), 32'd16);
    run_n(1);
    chk("halted_set", 32'(bus.halted), 32'd1);
    step(1, 0, 0, 1, 1, 4);
    step(1, 0, 0, 1, 1, 4);
    chk("halt_ignores_redir", 32'(bus.imem_addr), 32'd16);
    chk("halt_bubble", 32'(bus.valid_D), 32'd0);

    // Wrong-path halt squashed in HALT_PEND
    step(0, 0, 0, 0, 0, 0);
    run_n(6);
    step(1, 0, 0, 1, 1, 4);
    chk("squash_halted", 32'(bus.halted), 32'd0);
    chk("squash_addr", 32'(bus.imem_addr), 32'd4);
    run_n(1);
    chk("resume_p4", 32'(bus.pc_plus4_D), 32'd8);

    // Reset out of HALT with live counters
    for (int i = 0; i < 20 && !m_halted; i++) run_n(1);
    chk("reached_halt", 32'(bus.halted), 32'd1);
    step(0, 1, 0, 1, 1, 12);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_fetch_cnt", 32'(bus.fetch_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    chk("rst_valid", 32'(bus.valid_D), 32'd0);

    // Randomized traffic, saturation reachable with the narrow counters
    for (int i = 0; i < ADDR_N; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? HALT_INSTR_DEF : $urandom;
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 59) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 6) == 0,
           $urandom_range(0, 6) == 0,
           int'($urandom_range(0, ADDR_N - 1)));
    end

    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
`default_nettype wire
